// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: issues one outstanding fetch at a time to a variable-latency
// memory port and buffers returned {pc, instruction} pairs in a small prefetch queue.
module if_stage_prefetch #(
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    PC_STEP     = 1,
    parameter logic [WORD_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic                  mem_req,
    output logic [WORD_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] instruction
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [WORD_WIDTH-1:0] fetch_pc;
    logic [WORD_WIDTH-1:0] req_pc;
    logic                  busy;
    logic                  drop;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic [WORD_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [WORD_WIDTH-1:0] q_instr [QUEUE_DEPTH];

    logic             resp;
    logic             push;
    logic             pop;
    logic             issue;
    logic [CNT_W:0]   occupancy;

    // Occupancy includes the in-flight fetch; a same-cycle pop is deliberately not credited.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(busy);
    assign resp      = mem_rvalid && busy;
    assign push      = resp && !drop && !branch_taken;
    assign pop       = valid && !freeze && !branch_taken;
    assign issue     = !rst && !branch_taken && (!busy || mem_rvalid) &&
                       (occupancy < (CNT_W + 1)'(QUEUE_DEPTH));

    assign mem_req     = issue;
    assign mem_addr    = fetch_pc;
    assign valid       = (count != '0);
    assign pc          = valid ? q_pc[rd_ptr]    : '0;
    assign instruction = valid ? q_instr[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            busy     <= 1'b0;
            drop     <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                busy <= 1'b1;
            end else if (resp) begin
                busy <= 1'b0;
            end

            // A redirect with a fetch still pending poisons that response.
            if (branch_taken && busy && !mem_rvalid) begin
                drop <= 1'b1;
            end else if (resp) begin
                drop <= 1'b0;
            end

            if (branch_taken) begin
                fetch_pc <= branch_addr;
            end else if (issue) begin
                fetch_pc <= fetch_pc + WORD_WIDTH'(PC_STEP);
            end

            if (branch_taken) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc <= fetch_pc;
        end
        if (push) begin
            q_pc[wr_ptr]    <= req_pc;
            q_instr[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch with a behavioural fixed-latency memory
// that answers each request with data = address + 0x100.
module tb_if_stage_prefetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    logic        auto_en = 1'b1;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;

    if_stage_prefetch #(
        .WORD_WIDTH (32),
        .PC_STEP    (1),
        .RESET_PC   (32'h0),
        .QUEUE_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .valid       (valid),
        .pc          (pc),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            rsp_cnt <= 0;
        end else if (mem_req) begin
            rsp_cnt  <= lat;
            rsp_addr <= mem_addr;
        end else if (rsp_cnt > 0) begin
            rsp_cnt <= rsp_cnt - 1;
        end
    end

    assign mem_rvalid = auto_en ? (rsp_cnt == 1) : man_rvalid;
    assign mem_rdata  = auto_en ? (rsp_addr + 32'h100) : man_rdata;

    typedef struct {
        logic        frz;
        logic        evalid;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic frz, logic ev, logic [31:0] epc, logic er, logic [31:0] ea);
        vec_t v;
        v.frz = frz; v.evalid = ev; v.epc = epc; v.ereq = er; v.eaddr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        freeze = 1'b0;
        branch_taken = 1'b0;
        auto_en = 1'b1;
        man_rvalid = 1'b0;
        lat = l;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic er, input logic [31:0] ea);
        logic [31:0] einstr;
        einstr = ev ? epc + 32'h100 : 32'h0;
        chk({tag, ".valid"}, 32'(valid), 32'(ev));
        chk({tag, ".pc"}, pc, ev ? epc : 32'h0);
        chk({tag, ".instr"}, instruction, einstr);
        chk({tag, ".req"}, 32'(mem_req), 32'(er));
        if (er) chk({tag, ".addr"}, mem_addr, ea);
    endtask

    task automatic run_table(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            freeze = tbl[i].frz;
            #1;
            chk_out($sformatf("%s[%0d]", tag, i - lo), tbl[i].evalid, tbl[i].epc,
                    tbl[i].ereq, tbl[i].eaddr);
            tick();
        end
        freeze = 1'b0;
    endtask

    initial begin
        // Sequential fetch, 1-cycle memory, no freeze.
        tbl[0] = mk(0, 0, 0, 1, 0);
        tbl[1] = mk(0, 0, 0, 1, 1);
        tbl[2] = mk(0, 1, 0, 1, 2);
        tbl[3] = mk(0, 1, 1, 1, 3);
        tbl[4] = mk(0, 1, 2, 1, 4);
        tbl[5] = mk(0, 1, 3, 1, 5);
        // Freeze for 10 cycles from reset, then drain.
        tbl[6] = mk(1, 0, 0, 1, 0);
        tbl[7] = mk(1, 0, 0, 1, 1);
        tbl[8] = mk(1, 1, 0, 1, 2);
        tbl[9] = mk(1, 1, 0, 1, 3);
        for (int i = 10; i <= 15; i++) tbl[i] = mk(1, 1, 0, 0, 4);
        tbl[16] = mk(0, 1, 0, 0, 4);
        tbl[17] = mk(0, 1, 1, 1, 4);
        tbl[18] = mk(0, 1, 2, 1, 5);
        tbl[19] = mk(0, 1, 3, 1, 6);
        tbl[20] = mk(0, 1, 4, 1, 7);
        tbl[21] = mk(0, 1, 5, 1, 8);

        #1;
        chk("reset.valid", 32'(valid), 32'h0);
        chk("reset.req", 32'(mem_req), 32'h0);
        chk("reset.pc", pc, 32'h0);
        chk("reset.instr", instruction, 32'h0);

        do_reset(1);
        run_table(0, 5, "seq");
        do_reset(1);
        run_table(6, 21, "frz");

        // 3-cycle latency: one request every 3 cycles.
        do_reset(3);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("lat3[%0d].req", c), 32'(mem_req), 32'(c % 3 == 0));
            if (c % 3 == 0) chk($sformatf("lat3[%0d].addr", c), mem_addr, 32'(c / 3));
            if (c >= 4 && c % 3 == 1) begin
                chk($sformatf("lat3[%0d].valid", c), 32'(valid), 32'h1);
                chk($sformatf("lat3[%0d].pc", c), pc, 32'(c / 3 - 1));
            end else begin
                chk($sformatf("lat3[%0d].valid", c), 32'(valid), 32'h0);
            end
            tick();
        end

        // Branch while fetch of 5 is in flight and queue holds 2,3,4.
        do_reset(1);
        repeat (4) tick();
        freeze = 1'b1;
        tick();
        lat = 3;
        tick();
        branch_taken = 1'b1;
        branch_addr = 32'h40;
        #1;
        chk_out("brf.c6", 1'b1, 32'h2, 1'b0, 32'h0);
        tick();
        branch_taken = 1'b0;
        freeze = 1'b0;
        lat = 1;
        #1;
        chk_out("brf.c7", 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk_out("brf.c8", 1'b0, 32'h0, 1'b1, 32'h40);
        tick();
        chk_out("brf.c9", 1'b0, 32'h0, 1'b1, 32'h41);
        tick();
        chk_out("brf.c10", 1'b1, 32'h40, 1'b1, 32'h42);

        // Branch coinciding with a response and a pop.
        do_reset(1);
        repeat (2) tick();
        branch_taken = 1'b1;
        branch_addr = 32'h80;
        #1;
        chk("brr.c2.rvalid", 32'(mem_rvalid), 32'h1);
        chk_out("brr.c2", 1'b1, 32'h0, 1'b0, 32'h0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk_out("brr.c3", 1'b0, 32'h0, 1'b1, 32'h80);
        tick();
        chk_out("brr.c4", 1'b0, 32'h0, 1'b1, 32'h81);
        tick();
        chk_out("brr.c5", 1'b1, 32'h80, 1'b1, 32'h82);

        // Fetch PC wraps at the top of the address space.
        do_reset(1);
        branch_taken = 1'b1;
        branch_addr = 32'hFFFF_FFFF;
        tick();
        branch_taken = 1'b0;
        #1;
        chk_out("wrap.c1", 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        tick();
        chk_out("wrap.c2", 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        chk_out("wrap.c3", 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1);
        tick();
        chk_out("wrap.c4", 1'b1, 32'h0, 1'b1, 32'h2);

        // Asynchronous reset mid-cycle, then a stale response after release.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", 32'(valid), 32'h0);
        chk("arst.req", 32'(mem_req), 32'h0);
        chk("arst.addr", mem_addr, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        auto_en = 1'b0;
        man_rvalid = 1'b1;
        man_rdata = 32'hDEAD;
        #1;
        chk_out("late.c0", 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        man_rvalid = 1'b0;
        #1;
        chk_out("late.c1", 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        man_rvalid = 1'b1;
        man_rdata = 32'h100;
        #1;
        chk_out("late.c2", 1'b0, 32'h0, 1'b1, 32'h1);
        tick();
        man_rvalid = 1'b0;
        #1;
        chk_out("late.c3", 1'b1, 32'h0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
